// File: rtl/ppu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : ppu_issue_unit
// Description : Front-end sequencer for the PPU core. It buffers host posit
//               ops in an input FIFO and presents them to the PPU over a
//               valid/stall handshake. Each accepted op's host tag goes into
//               a tag FIFO. The PPU returns results in issue order; each
//               result is paired with the oldest tag and stored in a response
//               buffer drained by the host over valid/ready. A credit counter
//               caps the number of ops issued but not yet returned to the
//               host at MAX_INFL, so the response buffer can never overflow.
// Ports       : clk, rst (sync, active-low)
//               req_valid_i/req_ready_o/req_op_i/req_a_i/req_b_i/req_tag_i
//                   host request channel
//               ppu_valid_o/ppu_op_o/ppu_a_o/ppu_b_o/ppu_stall_i
//                   issue channel to the PPU
//               ppu_rvalid_i/ppu_result_i
//                   in-order PPU results
//               rsp_valid_o/rsp_ready_i/rsp_result_o/rsp_tag_o
//                   host response channel
//               busy_o  any op queued, in flight or buffered
//               wdog_err_o  sticky watchdog error (PPU_ISSUE_WDOG_EN only)
// Options     : PPU_ISSUE_WDOG_EN     adds the result watchdog and wdog_err_o
//               PPU_ISSUE_ASSERT_ON   enables the stray-result protocol check
// Revision    : 1.0  initial release
// ============================================================================
module ppu_issue_unit #(
    parameter int N        = 16,
    parameter int OP_SIZE  = 2,
    parameter int TAG_W    = 4,
    parameter int IQ_DEPTH = 4,
    parameter int MAX_INFL = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [OP_SIZE-1:0] req_op_i,
    input  logic [N-1:0]       req_a_i,
    input  logic [N-1:0]       req_b_i,
    input  logic [TAG_W-1:0]   req_tag_i,
    output logic               ppu_valid_o,
    output logic [OP_SIZE-1:0] ppu_op_o,
    output logic [N-1:0]       ppu_a_o,
    output logic [N-1:0]       ppu_b_o,
    input  logic               ppu_stall_i,
    input  logic               ppu_rvalid_i,
    input  logic [N-1:0]       ppu_result_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [N-1:0]       rsp_result_o,
    output logic [TAG_W-1:0]   rsp_tag_o,
    output logic               busy_o
`ifdef PPU_ISSUE_WDOG_EN
    ,
    output logic               wdog_err_o
`endif
);

    localparam int IQ_AW = $clog2(IQ_DEPTH);
    localparam int IQ_CW = IQ_AW + 1;
    localparam int IQ_W  = OP_SIZE + 2 * N + TAG_W;
    localparam int RB_AW = $clog2(MAX_INFL);
    localparam int RB_CW = RB_AW + 1;
    localparam int RB_W  = TAG_W + N;

    localparam logic [IQ_CW-1:0] IQ_FULL  = IQ_CW'(IQ_DEPTH);
    localparam logic [RB_CW-1:0] CRED_MAX = RB_CW'(MAX_INFL);

    // Pointer arithmetic relies on natural wrap, so depths must be powers of two.
    if ((IQ_DEPTH < 2) || ((IQ_DEPTH & (IQ_DEPTH - 1)) != 0) ||
        (MAX_INFL < 2) || ((MAX_INFL & (MAX_INFL - 1)) != 0) ||
        (TIMEOUT < 1)) begin : g_bad_params
        $error("ppu_issue_unit: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic ppu_valid;
    logic ppu_accept;
    logic issue_block;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [IQ_W-1:0]    iq_mem_q [IQ_DEPTH];
    logic [IQ_AW-1:0]   iq_wr_q, iq_rd_q;
    logic [IQ_CW-1:0]   iq_cnt_q, iq_cnt_d;
    logic               iq_push, iq_pop, iq_empty, iq_full;
    logic [OP_SIZE-1:0] head_op;
    logic [N-1:0]       head_a, head_b;
    logic [TAG_W-1:0]   head_tag;

    assign iq_full     = (iq_cnt_q == IQ_FULL);
    assign iq_empty    = (iq_cnt_q == '0);
    assign req_ready_o = !iq_full;
    assign iq_push     = req_valid_i && !iq_full;
    assign iq_pop      = ppu_accept;
    assign iq_cnt_d    = iq_cnt_q + IQ_CW'(iq_push) - IQ_CW'(iq_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            iq_wr_q  <= '0;
            iq_rd_q  <= '0;
            iq_cnt_q <= '0;
        end else begin
            if (iq_push) iq_wr_q <= iq_wr_q + IQ_AW'(1);
            if (iq_pop)  iq_rd_q <= iq_rd_q + IQ_AW'(1);
            iq_cnt_q <= iq_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (iq_push) iq_mem_q[iq_wr_q] <= {req_op_i, req_a_i, req_b_i, req_tag_i};
    end

    // The head entry is only popped on accept, so it stays bit-stable in HOLD.
    assign {head_op, head_a, head_b, head_tag} = iq_mem_q[iq_rd_q];

    // ------------------------------------------------------------------
    // Credits: taken on PPU accept, returned on host response handshake
    // ------------------------------------------------------------------
    logic [RB_CW-1:0] cred_q, cred_d;
    logic             rsp_pop;

    assign cred_d = cred_q - RB_CW'(ppu_accept) + RB_CW'(rsp_pop);

    always_ff @(posedge clk) begin
        if (!rst) cred_q <= CRED_MAX;
        else      cred_q <= cred_d;
    end

    // ------------------------------------------------------------------
    // Tag FIFO: tags of ops accepted by the PPU, oldest first
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] tq_mem_q [MAX_INFL];
    logic [RB_AW-1:0] tq_wr_q, tq_rd_q;
    logic [RB_CW-1:0] tq_cnt_q;
    logic             tq_push, tq_pop;

    assign tq_push = ppu_accept;
    // A result with no outstanding tag (e.g. a late result after reset) is dropped.
    assign tq_pop  = ppu_rvalid_i && (tq_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tq_wr_q  <= '0;
            tq_rd_q  <= '0;
            tq_cnt_q <= '0;
        end else begin
            if (tq_push) tq_wr_q <= tq_wr_q + RB_AW'(1);
            if (tq_pop)  tq_rd_q <= tq_rd_q + RB_AW'(1);
            tq_cnt_q <= tq_cnt_q + RB_CW'(tq_push) - RB_CW'(tq_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tq_push) tq_mem_q[tq_wr_q] <= head_tag;
    end

    // ------------------------------------------------------------------
    // Response buffer: {tag, result} pairs awaiting the host
    // ------------------------------------------------------------------
    logic [RB_W-1:0]  rb_mem_q [MAX_INFL];
    logic [RB_AW-1:0] rb_wr_q, rb_rd_q;
    logic [RB_CW-1:0] rb_cnt_q;
    logic             rb_push;
    logic [TAG_W-1:0] rb_tag;
    logic [N-1:0]     rb_res;

    assign rb_push     = tq_pop;
    assign rsp_valid_o = (rb_cnt_q != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rb_wr_q  <= '0;
            rb_rd_q  <= '0;
            rb_cnt_q <= '0;
        end else begin
            if (rb_push) rb_wr_q <= rb_wr_q + RB_AW'(1);
            if (rsp_pop) rb_rd_q <= rb_rd_q + RB_AW'(1);
            rb_cnt_q <= rb_cnt_q + RB_CW'(rb_push) - RB_CW'(rsp_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rb_push) rb_mem_q[rb_wr_q] <= {tq_mem_q[tq_rd_q], ppu_result_i};
    end

    assign {rb_tag, rb_res} = rb_mem_q[rb_rd_q];
    assign rsp_result_o     = rsp_valid_o ? rb_res : '0;
    assign rsp_tag_o        = rsp_valid_o ? rb_tag : '0;

    // ------------------------------------------------------------------
    // Watchdog on outstanding PPU results
    // ------------------------------------------------------------------
`ifdef PPU_ISSUE_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else if (ppu_rvalid_i || (tq_cnt_q == '0)) begin
            wd_cnt_q <= '0;
        end else if (!wd_err_q) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
            if (wd_cnt_q == WD_W'(TIMEOUT - 1)) wd_err_q <= 1'b1;
        end
    end

    assign wdog_err_o  = wd_err_q;
    assign issue_block = wd_err_q;
`else
    assign issue_block = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    assign ppu_accept = (state_q != S_IDLE) && !ppu_stall_i;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ppu_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!iq_empty && (cred_q != '0) && !issue_block) state_d = S_ISSUE;
            end
            S_ISSUE, S_HOLD: begin
                ppu_valid = 1'b1;
                if (ppu_stall_i) begin
                    state_d = issue_block ? S_IDLE : S_HOLD;
                end else if ((iq_cnt_d != '0) && (cred_d != '0) && !issue_block) begin
                    // Next head and a credit are both available: issue back-to-back.
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ppu_valid_o = ppu_valid;
    assign ppu_op_o    = ppu_valid ? head_op : '0;
    assign ppu_a_o     = ppu_valid ? head_a  : '0;
    assign ppu_b_o     = ppu_valid ? head_b  : '0;

    assign busy_o = !iq_empty || (cred_q != CRED_MAX);

`ifdef PPU_ISSUE_ASSERT_ON
    // Results must only arrive for ops that are actually outstanding.
    a_no_stray_result: assert property (@(posedge clk) disable iff (!rst)
        ppu_rvalid_i |-> (tq_cnt_q != '0));
`endif

endmodule
`default_nettype wire
